// File: rtl/spu_writeback_stage_if.sv
// Result, operand-query and write-back signal bundle between the SPU EX/REG
// stages and the write-back staging block.
interface spu_writeback_stage_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7
);
    // EX results: a result is offered on a pipe whenever valid_EXn is high.
    // There is no back-pressure; refusals are reported afterwards as pulses.
    logic              valid_EX1, valid_EX2;
    logic              regWriteEnable_EX1, regWriteEnable_EX2;
    logic [ADDR_W-1:0] writeRegister_EX1, writeRegister_EX2;
    logic [DATA_W-1:0] result_EX1, result_EX2;
    logic [2:0]        latency_EX1, latency_EX2;

    logic [ADDR_W-1:0] readRegisterRA_REG1, readRegisterRB_REG1;
    logic [ADDR_W-1:0] readRegisterRA_REG2, readRegisterRB_REG2;

    logic              regWriteEnable_WB1, regWriteEnable_WB2;
    logic [ADDR_W-1:0] writeRegister_WB1, writeRegister_WB2;
    logic [DATA_W-1:0] writeData_WB1, writeData_WB2;

    logic              fwdHit_RA1, fwdHit_RB1, fwdHit_RA2, fwdHit_RB2;
    logic [DATA_W-1:0] fwdData_RA1, fwdData_RB1, fwdData_RA2, fwdData_RB2;
    logic              busy_RA1, busy_RB1, busy_RA2, busy_RB2;
    logic              collision_WB1, collision_WB2;
    logic              latErr_WB1, latErr_WB2;

    modport slave (
        input  valid_EX1, valid_EX2, regWriteEnable_EX1, regWriteEnable_EX2,
        input  writeRegister_EX1, writeRegister_EX2, result_EX1, result_EX2,
        input  latency_EX1, latency_EX2,
        input  readRegisterRA_REG1, readRegisterRB_REG1,
        input  readRegisterRA_REG2, readRegisterRB_REG2,
        output regWriteEnable_WB1, regWriteEnable_WB2,
        output writeRegister_WB1, writeRegister_WB2, writeData_WB1, writeData_WB2,
        output fwdHit_RA1, fwdHit_RB1, fwdHit_RA2, fwdHit_RB2,
        output fwdData_RA1, fwdData_RB1, fwdData_RA2, fwdData_RB2,
        output busy_RA1, busy_RB1, busy_RA2, busy_RB2,
        output collision_WB1, collision_WB2, latErr_WB1, latErr_WB2
    );

    modport master (
        output valid_EX1, valid_EX2, regWriteEnable_EX1, regWriteEnable_EX2,
        output writeRegister_EX1, writeRegister_EX2, result_EX1, result_EX2,
        output latency_EX1, latency_EX2,
        output readRegisterRA_REG1, readRegisterRB_REG1,
        output readRegisterRA_REG2, readRegisterRB_REG2,
        input  regWriteEnable_WB1, regWriteEnable_WB2,
        input  writeRegister_WB1, writeRegister_WB2, writeData_WB1, writeData_WB2,
        input  fwdHit_RA1, fwdHit_RB1, fwdHit_RA2, fwdHit_RB2,
        input  fwdData_RA1, fwdData_RB1, fwdData_RA2, fwdData_RB2,
        input  busy_RA1, busy_RB1, busy_RA2, busy_RB2,
        input  collision_WB1, collision_WB2, latErr_WB1, latErr_WB2
    );
endinterface

// File: rtl/spu_writeback_stage.sv
// Dual-pipe result staging: each pipe's results ride a latency shift line and
// write the register file from slot 0, with slot-0 bypass and busy lookup.
module spu_writeback_stage #(
    parameter int MAX_LAT = 7,
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    spu_writeback_stage_if.slave   bus
);
    localparam int NP = 2;
    localparam int NQ = 4;

    logic              w_req    [NP];
    logic [2:0]        w_lat    [NP];
    logic [ADDR_W-1:0] w_waddr  [NP];
    logic [DATA_W-1:0] w_wdata  [NP];
    logic              w_lat_ok [NP];
    logic              w_coll   [NP];
    logic              w_ins    [NP];

    logic              r_vld  [NP][MAX_LAT];
    logic [ADDR_W-1:0] r_addr [NP][MAX_LAT];
    logic [DATA_W-1:0] r_data [NP][MAX_LAT];
    logic              w_nv   [NP][MAX_LAT];
    logic [ADDR_W-1:0] w_na   [NP][MAX_LAT];
    logic [DATA_W-1:0] w_nd   [NP][MAX_LAT];
    logic              r_coll   [NP];
    logic              r_laterr [NP];

    assign w_req[0]   = bus.valid_EX1 & bus.regWriteEnable_EX1;
    assign w_req[1]   = bus.valid_EX2 & bus.regWriteEnable_EX2;
    assign w_lat[0]   = bus.latency_EX1;
    assign w_lat[1]   = bus.latency_EX2;
    assign w_waddr[0] = bus.writeRegister_EX1;
    assign w_waddr[1] = bus.writeRegister_EX2;
    assign w_wdata[0] = bus.result_EX1;
    assign w_wdata[1] = bus.result_EX2;

    // A new entry for slot L-1 collides with whatever currently sits in slot L,
    // because that older entry shifts into the same place on this edge.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            w_lat_ok[p] = (w_lat[p] != 3'd0) && (int'(w_lat[p]) <= MAX_LAT);
            w_coll[p]   = 1'b0;
            for (int k = 1; k < MAX_LAT; k++) begin
                if (int'(w_lat[p]) == k && r_vld[p][k]) w_coll[p] = 1'b1;
            end
            w_coll[p] = w_coll[p] & w_req[p] & w_lat_ok[p];
            w_ins[p]  = w_req[p] & w_lat_ok[p] & ~w_coll[p];
        end
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < MAX_LAT - 1; k++) begin
                w_nv[p][k] = r_vld[p][k+1];
                w_na[p][k] = r_addr[p][k+1];
                w_nd[p][k] = r_data[p][k+1];
            end
            w_nv[p][MAX_LAT-1] = 1'b0;
            w_na[p][MAX_LAT-1] = r_addr[p][MAX_LAT-1];
            w_nd[p][MAX_LAT-1] = r_data[p][MAX_LAT-1];
            for (int k = 0; k < MAX_LAT; k++) begin
                if (w_ins[p] && int'(w_lat[p]) == k + 1) begin
                    w_nv[p][k] = 1'b1;
                    w_na[p][k] = w_waddr[p];
                    w_nd[p][k] = w_wdata[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int p = 0; p < NP; p++) begin
                r_coll[p]   <= 1'b0;
                r_laterr[p] <= 1'b0;
                for (int k = 0; k < MAX_LAT; k++) r_vld[p][k] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                r_coll[p]   <= w_coll[p];
                r_laterr[p] <= w_req[p] & ~w_lat_ok[p];
            end
            r_vld <= w_nv;
        end
        r_addr <= w_na;
        r_data <= w_nd;
    end

    logic [ADDR_W-1:0] w_q     [NQ];
    logic              w_hit   [NP][NQ];
    logic              w_fhit  [NQ];
    logic [DATA_W-1:0] w_fdata [NQ];
    logic              w_busy  [NQ];

    assign w_q[0] = bus.readRegisterRA_REG1;
    assign w_q[1] = bus.readRegisterRB_REG1;
    assign w_q[2] = bus.readRegisterRA_REG2;
    assign w_q[3] = bus.readRegisterRB_REG2;

    // Pipe 2 carries the younger result, so it wins the bypass on a tie.
    always_comb begin
        for (int q = 0; q < NQ; q++) begin
            for (int p = 0; p < NP; p++) begin
                w_hit[p][q] = r_vld[p][0] && (r_addr[p][0] == w_q[q]);
            end
            w_fhit[q]  = w_hit[0][q] | w_hit[1][q];
            w_fdata[q] = w_hit[1][q] ? r_data[1][0] :
                         w_hit[0][q] ? r_data[0][0] : '0;
            w_busy[q]  = 1'b0;
            for (int p = 0; p < NP; p++) begin
                for (int k = 1; k < MAX_LAT; k++) begin
                    if (r_vld[p][k] && r_addr[p][k] == w_q[q]) w_busy[q] = 1'b1;
                end
            end
        end
    end

    assign bus.regWriteEnable_WB1 = r_vld[0][0] &
                                    ~(r_vld[1][0] && r_addr[1][0] == r_addr[0][0]);
    assign bus.regWriteEnable_WB2 = r_vld[1][0];
    assign bus.writeRegister_WB1  = r_vld[0][0] ? r_addr[0][0] : '0;
    assign bus.writeRegister_WB2  = r_vld[1][0] ? r_addr[1][0] : '0;
    assign bus.writeData_WB1      = r_vld[0][0] ? r_data[0][0] : '0;
    assign bus.writeData_WB2      = r_vld[1][0] ? r_data[1][0] : '0;

    assign bus.fwdHit_RA1  = w_fhit[0];
    assign bus.fwdHit_RB1  = w_fhit[1];
    assign bus.fwdHit_RA2  = w_fhit[2];
    assign bus.fwdHit_RB2  = w_fhit[3];
    assign bus.fwdData_RA1 = w_fdata[0];
    assign bus.fwdData_RB1 = w_fdata[1];
    assign bus.fwdData_RA2 = w_fdata[2];
    assign bus.fwdData_RB2 = w_fdata[3];
    assign bus.busy_RA1    = w_busy[0];
    assign bus.busy_RB1    = w_busy[1];
    assign bus.busy_RA2    = w_busy[2];
    assign bus.busy_RB2    = w_busy[3];

    assign bus.collision_WB1 = r_coll[0];
    assign bus.collision_WB2 = r_coll[1];
    assign bus.latErr_WB1    = r_laterr[0];
    assign bus.latErr_WB2    = r_laterr[1];
endmodule

// File: tb/tb_spu_writeback_stage.sv
// Bench for spu_writeback_stage: directed scenarios plus a randomized run
// against a due-cycle reference model of the staged results.
module tb_spu_writeback_stage;
    localparam int ML = 6;

    logic clk;
    logic reset;
    logic flush;
    int   n_cmp;
    int   n_bad;

    spu_writeback_stage_if #(.DATA_W(128), .ADDR_W(7)) bus ();

    spu_writeback_stage #(.MAX_LAT(ML), .DATA_W(128), .ADDR_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {wbe1, wbe2, hitRA1, hitRB1, hitRA2, hitRB2, busyRA1..busyRB2, coll1, coll2, lat1, lat2}
    logic [13:0]  flags;
    logic [269:0] wb_all;
    logic [511:0] fwd_all;
    assign flags = {bus.regWriteEnable_WB1, bus.regWriteEnable_WB2,
                    bus.fwdHit_RA1, bus.fwdHit_RB1, bus.fwdHit_RA2, bus.fwdHit_RB2,
                    bus.busy_RA1, bus.busy_RB1, bus.busy_RA2, bus.busy_RB2,
                    bus.collision_WB1, bus.collision_WB2, bus.latErr_WB1, bus.latErr_WB2};
    assign wb_all  = {bus.writeRegister_WB1, bus.writeRegister_WB2,
                      bus.writeData_WB1, bus.writeData_WB2};
    assign fwd_all = {bus.fwdData_RA1, bus.fwdData_RB1, bus.fwdData_RA2, bus.fwdData_RB2};

    typedef struct {
        int           pipe;
        int           due;
        logic [6:0]   addr;
        logic [127:0] data;
    } ent_t;

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        bus.valid_EX1 = 1'b0; bus.regWriteEnable_EX1 = 1'b0;
        bus.valid_EX2 = 1'b0; bus.regWriteEnable_EX2 = 1'b0;
        bus.writeRegister_EX1 = '0; bus.writeRegister_EX2 = '0;
        bus.result_EX1 = '0; bus.result_EX2 = '0;
        bus.latency_EX1 = '0; bus.latency_EX2 = '0;
    endtask

    task automatic set_queries(input logic [6:0] a, input logic [6:0] b,
                               input logic [6:0] c, input logic [6:0] d);
        bus.readRegisterRA_REG1 = a; bus.readRegisterRB_REG1 = b;
        bus.readRegisterRA_REG2 = c; bus.readRegisterRB_REG2 = d;
    endtask

    task automatic issue(input int pipe, input logic [6:0] addr,
                         input logic [127:0] data, input logic [2:0] lat);
        if (pipe == 1) begin
            bus.valid_EX1 = 1'b1; bus.regWriteEnable_EX1 = 1'b1;
            bus.writeRegister_EX1 = addr; bus.result_EX1 = data; bus.latency_EX1 = lat;
        end else begin
            bus.valid_EX2 = 1'b1; bus.regWriteEnable_EX2 = 1'b1;
            bus.writeRegister_EX2 = addr; bus.result_EX2 = data; bus.latency_EX2 = lat;
        end
    endtask

    task automatic drain();
        clear_ex();
        set_queries(7'd0, 7'd0, 7'd0, 7'd0);
        repeat (ML + 1) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        issue(1, 7'd3, rnd128(), 3'd1);
        issue(2, 7'd3, rnd128(), 3'd2);
        set_queries(7'd3, 7'd3, 7'd3, 7'd3);
        tick();
        tick();
        n_cmp++;
        if (flags !== 14'd0) begin
            n_bad++; $display("FAIL reset_flags got %b exp 0", flags);
        end
        n_cmp++;
        if (wb_all !== '0 || fwd_all !== '0) begin
            n_bad++; $display("FAIL reset_data got wb %h fwd %h exp 0", wb_all, fwd_all);
        end
        reset = 1'b0;
        clear_ex();
        tick();
        n_cmp++;
        if (flags !== 14'd0) begin
            n_bad++; $display("FAIL post_reset_flags got %b exp 0", flags);
        end
    endtask

    task automatic test_single_write();
        logic [127:0] d;
        d = {4{32'hA5A5A5A5}};
        drain();
        issue(1, 7'd5, d, 3'd1);
        set_queries(7'd5, 7'd0, 7'd0, 7'd0);
        tick();
        clear_ex();
        n_cmp++;
        if ({bus.regWriteEnable_WB1, bus.writeRegister_WB1, bus.writeData_WB1} !== {1'b1, 7'd5, d}) begin
            n_bad++; $display("FAIL single_write got %b %0d %h exp 1 5 %h",
                              bus.regWriteEnable_WB1, bus.writeRegister_WB1, bus.writeData_WB1, d);
        end
        n_cmp++;
        if ({bus.fwdHit_RA1, bus.fwdData_RA1} !== {1'b1, d}) begin
            n_bad++; $display("FAIL single_fwd got %b %h exp 1 %h", bus.fwdHit_RA1, bus.fwdData_RA1, d);
        end
        tick();
        n_cmp++;
        if ({bus.regWriteEnable_WB1, bus.fwdHit_RA1} !== 2'b00) begin
            n_bad++; $display("FAIL single_done got %b%b exp 00", bus.regWriteEnable_WB1, bus.fwdHit_RA1);
        end
    endtask

    task automatic test_busy_forward();
        logic [127:0] d;
        d = rnd128();
        drain();
        issue(2, 7'd9, d, 3'd6);
        set_queries(7'd9, 7'd0, 7'd0, 7'd0);
        tick();
        clear_ex();
        for (int c = 1; c <= 6; c++) begin
            if (c < 6) begin
                n_cmp++;
                if ({bus.busy_RA1, bus.fwdHit_RA1} !== 2'b10) begin
                    n_bad++; $display("FAIL busy_c%0d got busy %b hit %b exp 1 0", c, bus.busy_RA1, bus.fwdHit_RA1);
                end
                tick();
            end else begin
                n_cmp++;
                if ({bus.busy_RA1, bus.fwdHit_RA1, bus.regWriteEnable_WB2, bus.fwdData_RA1} !== {3'b011, d}) begin
                    n_bad++; $display("FAIL fwd_c6 got busy %b hit %b wbe2 %b data %h exp 0 1 1 %h",
                                      bus.busy_RA1, bus.fwdHit_RA1, bus.regWriteEnable_WB2, bus.fwdData_RA1, d);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [127:0] d1;
        logic [127:0] d2;
        int strobes;
        d1 = rnd128();
        d2 = rnd128();
        strobes = 0;
        drain();
        issue(1, 7'd20, d1, 3'd4);
        tick();
        n_cmp++;
        if (bus.collision_WB1 !== 1'b0) begin
            n_bad++; $display("FAIL coll_c1 got %b exp 0", bus.collision_WB1);
        end
        issue(1, 7'd21, d2, 3'd3);
        tick();
        clear_ex();
        n_cmp++;
        if ({bus.collision_WB1, bus.collision_WB2} !== 2'b10) begin
            n_bad++; $display("FAIL coll_c2 got %b%b exp 10", bus.collision_WB1, bus.collision_WB2);
        end
        strobes += int'(bus.regWriteEnable_WB1);
        for (int c = 3; c <= 8; c++) begin
            tick();
            strobes += int'(bus.regWriteEnable_WB1);
            if (c == 3) begin
                n_cmp++;
                if (bus.collision_WB1 !== 1'b0) begin
                    n_bad++; $display("FAIL coll_c3 got %b exp 0", bus.collision_WB1);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if ({bus.regWriteEnable_WB1, bus.writeRegister_WB1, bus.writeData_WB1} !== {1'b1, 7'd20, d1}) begin
                    n_bad++; $display("FAIL coll_write got %b %0d %h exp 1 20 %h",
                                      bus.regWriteEnable_WB1, bus.writeRegister_WB1, bus.writeData_WB1, d1);
                end
            end
        end
        n_cmp++;
        if (strobes !== 1) begin
            n_bad++; $display("FAIL coll_strobes got %0d exp 1", strobes);
        end
    endtask

    task automatic test_same_addr();
        logic [127:0] d1;
        logic [127:0] d2;
        d1 = rnd128();
        d2 = rnd128();
        drain();
        issue(1, 7'd12, d1, 3'd2);
        issue(2, 7'd12, d2, 3'd2);
        set_queries(7'd0, 7'd0, 7'd12, 7'd0);
        tick();
        clear_ex();
        n_cmp++;
        if ({bus.busy_RA2, bus.fwdHit_RA2} !== 2'b10) begin
            n_bad++; $display("FAIL same_c1 got busy %b hit %b exp 1 0", bus.busy_RA2, bus.fwdHit_RA2);
        end
        tick();
        n_cmp++;
        if ({bus.regWriteEnable_WB1, bus.regWriteEnable_WB2, bus.writeRegister_WB2, bus.writeData_WB2}
            !== {2'b01, 7'd12, d2}) begin
            n_bad++; $display("FAIL same_wb got wbe %b%b reg %0d data %h exp 01 12 %h",
                              bus.regWriteEnable_WB1, bus.regWriteEnable_WB2,
                              bus.writeRegister_WB2, bus.writeData_WB2, d2);
        end
        n_cmp++;
        if ({bus.fwdHit_RA2, bus.fwdData_RA2} !== {1'b1, d2}) begin
            n_bad++; $display("FAIL same_fwd got %b %h exp 1 %h", bus.fwdHit_RA2, bus.fwdData_RA2, d2);
        end
        tick();
        n_cmp++;
        if ({bus.regWriteEnable_WB1, bus.regWriteEnable_WB2} !== 2'b00) begin
            n_bad++; $display("FAIL same_done got %b%b exp 00", bus.regWriteEnable_WB1, bus.regWriteEnable_WB2);
        end
    endtask

    task automatic test_lat_err();
        int strobes;
        strobes = 0;
        drain();
        issue(1, 7'd3, rnd128(), 3'd0);
        issue(2, 7'd4, rnd128(), 3'd7);
        set_queries(7'd3, 7'd4, 7'd3, 7'd4);
        tick();
        clear_ex();
        n_cmp++;
        if ({bus.latErr_WB1, bus.latErr_WB2, bus.collision_WB1, bus.collision_WB2} !== 4'b1100) begin
            n_bad++; $display("FAIL laterr_pulse got %b%b coll %b%b exp 11 00",
                              bus.latErr_WB1, bus.latErr_WB2, bus.collision_WB1, bus.collision_WB2);
        end
        // Discarded results (write enable low) never report a latency error.
        bus.valid_EX1 = 1'b1; bus.regWriteEnable_EX1 = 1'b0; bus.latency_EX1 = 3'd0;
        tick();
        clear_ex();
        n_cmp++;
        if ({bus.latErr_WB1, bus.latErr_WB2} !== 2'b00) begin
            n_bad++; $display("FAIL laterr_end got %b%b exp 00", bus.latErr_WB1, bus.latErr_WB2);
        end
        for (int c = 0; c < ML + 2; c++) begin
            strobes += int'(bus.regWriteEnable_WB1) + int'(bus.regWriteEnable_WB2);
            strobes += int'(bus.busy_RA1) + int'(bus.busy_RB1) + int'(bus.fwdHit_RA1);
            tick();
        end
        n_cmp++;
        if (strobes !== 0) begin
            n_bad++; $display("FAIL laterr_nowrite got %0d strobe/busy/hit exp 0", strobes);
        end
    endtask

    task automatic test_flush(input bit use_reset);
        drain();
        issue(1, 7'd30, rnd128(), 3'd6);
        issue(2, 7'd31, rnd128(), 3'd5);
        tick();
        clear_ex();
        issue(1, 7'd32, rnd128(), 3'd2);
        set_queries(7'd30, 7'd31, 7'd32, 7'd33);
        tick();
        n_cmp++;
        if ({bus.busy_RA1, bus.busy_RB1, bus.busy_RA2, bus.busy_RB2} !== 4'b1110) begin
            n_bad++; $display("FAIL flush_pre_busy rst=%0d got %b%b%b%b exp 1110", use_reset,
                              bus.busy_RA1, bus.busy_RB1, bus.busy_RA2, bus.busy_RB2);
        end
        clear_ex();
        issue(2, 7'd33, rnd128(), 3'd1);
        if (use_reset) reset = 1'b1;
        else flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        clear_ex();
        for (int c = 0; c < ML + 2; c++) begin
            n_cmp++;
            if (flags !== 14'd0 || wb_all !== '0 || fwd_all !== '0) begin
                n_bad++; $display("FAIL flush_c%0d rst=%0d got flags %b exp 0", c, use_reset, flags);
            end
            tick();
        end
    endtask

    task automatic test_random(input int ncyc);
        ent_t         mq[$];
        int           c;
        logic         v [2];
        logic         w [2];
        logic [2:0]   l [2];
        logic [6:0]   a [2];
        logic [127:0] d [2];
        logic [6:0]   qa [4];
        logic         fl;
        logic         e_coll [2];
        logic         e_lat  [2];
        logic         s0v [2];
        logic [6:0]   s0a [2];
        logic [127:0] s0d [2];
        logic         e_hit  [4];
        logic         e_busy [4];
        logic [127:0] e_fd   [4];
        logic [13:0]  e_flags;
        logic [269:0] e_wb;
        logic [511:0] e_fwd;
        bit           clash;

        clear_ex();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        c = 0;
        for (int i = 0; i < ncyc; i++) begin
            for (int p = 0; p < 2; p++) begin
                v[p] = ($urandom_range(0, 3) != 0);
                w[p] = ($urandom_range(0, 5) != 0);
                l[p] = 3'($urandom_range(0, 7));
                a[p] = 7'($urandom_range(0, 7));
                d[p] = rnd128();
            end
            for (int q = 0; q < 4; q++) qa[q] = 7'($urandom_range(0, 7));
            fl = ($urandom_range(0, 31) == 0);
            bus.valid_EX1 = v[0]; bus.regWriteEnable_EX1 = w[0]; bus.latency_EX1 = l[0];
            bus.writeRegister_EX1 = a[0]; bus.result_EX1 = d[0];
            bus.valid_EX2 = v[1]; bus.regWriteEnable_EX2 = w[1]; bus.latency_EX2 = l[1];
            bus.writeRegister_EX2 = a[1]; bus.result_EX2 = d[1];
            set_queries(qa[0], qa[1], qa[2], qa[3]);
            flush = fl;
            tick();

            // Model the edge that ends cycle c: results due at c retire, new ones get due c+L.
            for (int p = 0; p < 2; p++) begin
                e_coll[p] = 1'b0;
                e_lat[p]  = 1'b0;
            end
            if (fl) begin
                mq.delete();
            end else begin
                for (int j = mq.size() - 1; j >= 0; j--) begin
                    if (mq[j].due == c) mq.delete(j);
                end
                for (int p = 0; p < 2; p++) begin
                    if (v[p] && w[p]) begin
                        if (l[p] == 3'd0 || int'(l[p]) > ML) begin
                            e_lat[p] = 1'b1;
                        end else begin
                            clash = 1'b0;
                            foreach (mq[j]) begin
                                if (mq[j].pipe == p && mq[j].due == c + int'(l[p])) clash = 1'b1;
                            end
                            if (clash) e_coll[p] = 1'b1;
                            else mq.push_back('{p, c + int'(l[p]), a[p], d[p]});
                        end
                    end
                end
            end
            c++;

            for (int p = 0; p < 2; p++) begin
                s0v[p] = 1'b0; s0a[p] = '0; s0d[p] = '0;
            end
            foreach (mq[j]) begin
                if (mq[j].due == c) begin
                    s0v[mq[j].pipe] = 1'b1;
                    s0a[mq[j].pipe] = mq[j].addr;
                    s0d[mq[j].pipe] = mq[j].data;
                end
            end
            for (int q = 0; q < 4; q++) begin
                e_busy[q] = 1'b0;
                foreach (mq[j]) begin
                    if (mq[j].due > c && mq[j].addr == qa[q]) e_busy[q] = 1'b1;
                end
                e_hit[q] = (s0v[0] && s0a[0] == qa[q]) || (s0v[1] && s0a[1] == qa[q]);
                if (s0v[1] && s0a[1] == qa[q]) e_fd[q] = s0d[1];
                else if (s0v[0] && s0a[0] == qa[q]) e_fd[q] = s0d[0];
                else e_fd[q] = '0;
            end
            e_flags = {s0v[0] && !(s0v[1] && s0a[1] == s0a[0]), s0v[1],
                       e_hit[0], e_hit[1], e_hit[2], e_hit[3],
                       e_busy[0], e_busy[1], e_busy[2], e_busy[3],
                       e_coll[0], e_coll[1], e_lat[0], e_lat[1]};
            e_wb  = {s0a[0], s0a[1], s0d[0], s0d[1]};
            e_fwd = {e_fd[0], e_fd[1], e_fd[2], e_fd[3]};

            n_cmp++;
            if (flags !== e_flags) begin
                n_bad++; $display("FAIL rand_flags cyc %0d got %b exp %b", c, flags, e_flags);
            end
            n_cmp++;
            if (wb_all !== e_wb) begin
                n_bad++; $display("FAIL rand_wb cyc %0d got %h exp %h", c, wb_all, e_wb);
            end
            n_cmp++;
            if (fwd_all !== e_fwd) begin
                n_bad++; $display("FAIL rand_fwd cyc %0d got %h exp %h", c, fwd_all, e_fwd);
            end
        end
        flush = 1'b0;
        clear_ex();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        flush = 1'b0;
        clear_ex();
        set_queries(7'd0, 7'd0, 7'd0, 7'd0);
        test_reset();
        test_single_write();
        test_busy_forward();
        test_collision();
        test_same_addr();
        test_lat_err();
        test_flush(1'b0);
        test_flush(1'b1);
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
